ram_rd_stream_ctrl: RTL and testbench

Read-side controller for the dual-clock-capable generic RAM (independent read/write ports) used as frame/line storage in the motion-segmentation pipeline. On a start command it walks a contiguous, wrap-around address range on the RAM read port, absorbs the RAM's one-cycle registered read latency, and presents the words as a valid/ready stream with a last-word marker to the downstream processing stage. It runs entirely in the RAM read-port clock domain and supports full 1 word/cycle throughput under arbitrary backpressure.

---
 rtl/ram_rd_stream_ctrl_pkg.sv | 24 ++
 rtl/ram_rd_stream_ctrl_skid_fifo_2.sv | 53 +++++
 rtl/ram_rd_stream_ctrl.sv | 109 ++++++++++
 tb/tb_ram_rd_stream_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_stream_ctrl_pkg.sv
// Shared definitions for the RAM read/write stream controllers:
// FSM state encoding and the address-width helper.
package ram_rd_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Number of bits needed to hold 'value' (minimum 1).
  function automatic int ceil_log2(input int value);
    int unsigned v;
    int          bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/ram_rd_stream_ctrl_skid_fifo_2.sv
// Two-entry output FIFO. The head is always entry 0, so the head data is
// driven straight from a register and only changes on pop or push-into-empty.
module skid_fifo_2 #(
  parameter int DATA_BITS = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [DATA_BITS-1:0] head_data
);

  logic [DATA_BITS-1:0] head_q;
  logic [DATA_BITS-1:0] tail_q;
  logic [1:0]           count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);
  assign head_data = head_q;

endmodule

// File: rtl/ram_rd_stream_ctrl.sv
// Read-side RAM controller: walks a wrap-around address range, absorbs the
// RAM's one-cycle read latency and presents the words as a valid/ready stream.
module ram_rd_stream_ctrl
  import ram_rd_stream_ctrl_pkg::*;
#(
  parameter int  WORDS_COUNT   = 512,
  parameter int  WORDS_BITS    = 8,
  parameter int  ADDR_BITS     = 0,
  localparam int LOC_ADDR_BITS = (ADDR_BITS == 0) ? ceil_log2(WORDS_COUNT - 1) : ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LOC_ADDR_BITS-1:0] start_addr,
  input  logic [LOC_ADDR_BITS:0]   rd_count,
  output logic                     busy,
  output logic                     done,
  output logic [LOC_ADDR_BITS-1:0] ram_rd_addr,
  input  logic [WORDS_BITS-1:0]    ram_rd_dout,
  output logic [WORDS_BITS-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam logic [LOC_ADDR_BITS-1:0] LAST_ADDR = LOC_ADDR_BITS'(WORDS_COUNT - 1);
  localparam logic [LOC_ADDR_BITS:0]   ONE_LEFT  = (LOC_ADDR_BITS + 1)'(1);

  rd_state_e                  state_q, state_d;
  logic [LOC_ADDR_BITS-1:0]   addr_q;
  logic [LOC_ADDR_BITS-1:0]   next_addr;
  logic [LOC_ADDR_BITS:0]     remain_q;
  logic                       inflight_q;
  logic                       inflight_last_q;
  logic                       zero_done_q;
  logic                       accept;
  logic                       issue;
  logic                       credit_ok;
  logic                       pop;
  logic                       last_pop;
  logic [1:0]                 occupancy;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [WORDS_BITS:0]        fifo_head;

  assign accept    = (state_q == ST_IDLE) && start && (rd_count != '0);
  assign pop       = m_valid && m_ready;
  assign last_pop  = pop && fifo_head[WORDS_BITS];
  assign occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);

  // occupancy + inflight - pop <= 1, rearranged to stay unsigned.
  assign credit_ok = ({1'b0, occupancy} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});
  assign issue     = (state_q == ST_RUN) && credit_ok;
  assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + LOC_ADDR_BITS'(1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (issue && (remain_q == ONE_LEFT)) state_d = ST_DRAIN;
      ST_DRAIN: if (last_pop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (remain_q == ONE_LEFT);
      zero_done_q     <= (state_q == ST_IDLE) && start && (rd_count == '0);
      if (accept) begin
        addr_q   <= start_addr;
        remain_q <= rd_count;
      end else if (issue) begin
        addr_q   <= next_addr;
        remain_q <= remain_q - ONE_LEFT;
      end
    end
  end

  skid_fifo_2 #(
    .DATA_BITS(WORDS_BITS + 1)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data({inflight_last_q, ram_rd_dout}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_data(fifo_head)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = zero_done_q || last_pop;
  assign ram_rd_addr = addr_q;
  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_head[WORDS_BITS-1:0];
  assign m_last      = fifo_head[WORDS_BITS] && !fifo_empty;

endmodule

// File: tb/tb_ram_rd_stream_ctrl.sv
// Scoreboard bench for ram_rd_stream_ctrl on a 300-word RAM holding mem[i] = i.
module tb_ram_rd_stream_ctrl;

  localparam int WC = 300;
  localparam int WB = 16;
  localparam int AB = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] start_addr = '0;
  logic [AB:0]   rd_count = '0;
  logic          busy, done;
  logic [AB-1:0] ram_rd_addr;
  logic [WB-1:0] ram_rd_dout = '0;
  logic [WB-1:0] m_data;
  logic          m_valid, m_last;
  logic          m_ready = 1'b1;

  logic [WB-1:0] mem [WC];

  typedef struct {
    logic [WB-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_cnt = 0;
  int   done_cyc = -1;
  bit   zero_pending = 0;
  int   ready_mode = 0;
  int   pidx = 0;
  bit   pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  ram_rd_stream_ctrl #(
    .WORDS_COUNT(WC),
    .WORDS_BITS (WB),
    .ADDR_BITS  (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .rd_count   (rd_count),
    .busy       (busy),
    .done       (done),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_dout(ram_rd_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < WC; i++) mem[i] = WB'(i);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_rd_addr < AB'(WC)) ram_rd_dout <= mem[ram_rd_addr];
    else                       ram_rd_dout <= 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready driver
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin m_ready = pat[pidx % 8]; pidx++; end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every handshake
  initial begin
    bit            prev_stall;
    logic [WB-1:0] prev_data;
    exp_t          e;
    prev_stall = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        chk("addr_in_range", 32'(ram_rd_addr < AB'(WC)), 1);
        if (prev_stall) begin
          chk("stall_valid_held", 32'(m_valid), 1);
          chk("stall_data_held", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_word", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", 32'(m_data), 32'(e.data));
            chk("m_last", 32'(m_last), 32'(e.last));
            chk("done_on_handshake", 32'(done), 32'(e.last));
          end
          hs_cnt++;
        end else begin
          chk("done_no_handshake", 32'(done), 32'(zero_pending));
          zero_pending = 0;
        end
        if (done) done_cyc = cyc;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  task automatic issue_start(input int sa, input int n, output int s0);
    exp_t e;
    start_addr = AB'(sa);
    rd_count   = (AB + 1)'(n);
    start      = 1'b1;
    for (int k = 0; k < n; k++) begin
      e.data = WB'((sa + k) % WC);
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    s0 = cyc;
    if (n == 0) zero_pending = 1;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !zero_pending) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(input int sa, input int n, input int mode, input bit timing);
    int            s0;
    logic [AB-1:0] addr_before;
    ready_mode  = mode;
    pidx        = 0;
    addr_before = ram_rd_addr;
    done_cyc    = -1;
    issue_start(sa, n, s0);
    if (n == 0) begin
      @(negedge clk);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_valid", 32'(m_valid), 0);
      chk("zero_addr_held", 32'(ram_rd_addr), 32'(addr_before));
    end else if (timing) begin
      @(negedge clk);
      chk("lat_addr_c0", 32'(ram_rd_addr), 32'(sa));
      chk("lat_busy_c0", 32'(busy), 1);
      chk("lat_valid_c0", 32'(m_valid), 0);
      @(negedge clk);
      chk("lat_valid_c1", 32'(m_valid), 0);
      @(negedge clk);
      chk("lat_valid_c2", 32'(m_valid), 1);
    end
    wait_idle(4 * n + 40);
    if (timing && n > 0) chk("done_cycle", 32'(done_cyc - s0), 32'(n + 1));
    chk("busy_after", 32'(busy), 0);
  endtask

  initial begin
    int s0;
    int target;
    bit reached;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_addr", 32'(ram_rd_addr), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_xfer(10, 4, 0, 1);
    run_xfer(298, 4, 0, 1);
    run_xfer(0, 8, 1, 0);
    run_xfer(5, 0, 0, 0);
    run_xfer(0, 300, 0, 1);
    run_xfer(299, 1, 0, 1);

    // start while busy must be ignored
    ready_mode = 0;
    issue_start(50, 10, s0);
    @(posedge clk);
    #1;
    start_addr = AB'(200);
    rd_count   = (AB + 1)'(5);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(80);

    // reset in the middle of a transfer
    ready_mode = 0;
    target = hs_cnt + 3;
    issue_start(100, 10, s0);
    reached = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (hs_cnt >= target) begin
        reached = 1;
        break;
      end
    end
    chk("reached_3_words", 32'(reached), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_valid", 32'(m_valid), 0);
    chk("midrst_last", 32'(m_last), 0);
    chk("midrst_data", 32'(m_data), 0);
    chk("midrst_addr", 32'(ram_rd_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("inrst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_valid", 32'(m_valid), 0);
    run_xfer(120, 6, 0, 1);

    for (int t = 0; t < 14; t++) begin
      int sa, n;
      sa = $urandom_range(0, WC - 1);
      n  = (t % 7 == 6) ? 0 : $urandom_range(1, 40);
      run_xfer(sa, n, 2, 0);
    end
    run_xfer(290, 25, 2, 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
